// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_pkg : shared PC constants, stage payload widths and offsets
// Rev 1.0
// ---------------------------------------------------------------
package pipe_pkg;

   localparam logic [31:0] RESET_PC_C = 32'h0000_3004;
   localparam logic [31:0] EXC_PC_C   = 32'h0000_4184;
   localparam logic [31:0] CLR_PC_C   = 32'h0000_0000;

   // EX/MA payload; other stages follow the same packed layout style
   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        rd_we;
      logic        mem_rd;
      logic        mem_wr;
      logic [2:0]  mem_size;
   } ex_ma_t;

   localparam int IF_ID_W = 64;
   localparam int ID_EX_W = 128;
   localparam int EX_MA_W = $bits(ex_ma_t);
   localparam int MA_WB_W = 40;

   localparam int EX_MA_MEM_SIZE_LSB = 0;
   localparam int EX_MA_MEM_WR_LSB   = 3;
   localparam int EX_MA_MEM_RD_LSB   = 4;
   localparam int EX_MA_RD_WE_LSB    = 5;
   localparam int EX_MA_RD_LSB       = 6;
   localparam int EX_MA_STORE_LSB    = 11;
   localparam int EX_MA_RESULT_LSB   = 43;

endpackage
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_entry : one {valid, data, pc} register with load/drop/flush
// Rev 1.0
// ---------------------------------------------------------------
module pipe_entry #(
   parameter int              DATA_W   = 128,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [PC_W-1:0]   inject_pc,
   input  logic              load,
   input  logic              drop,
   input  logic [DATA_W-1:0] load_data,
   input  logic [PC_W-1:0]   load_pc,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [PC_W-1:0]   pc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         pc    <= RESET_PC;
      end else if (flush) begin
         valid <= 1'b0;
         data  <= '0;
         pc    <= inject_pc;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         pc    <= load_pc;
      end else if (drop) begin
         // payload is kept so the outputs stay stable after a pop
         valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_stage_skid : pipeline stage register with 2-entry skid buffer
// Optional macro PIPE_STAGE_PERF_EN adds stall_cnt / flush_cnt.
// Rev 1.0
// ---------------------------------------------------------------
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int              DATA_W   = 128,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_C,
   parameter logic [PC_W-1:0] EXC_PC   = EXC_PC_C,
   parameter logic [PC_W-1:0] CLR_PC   = CLR_PC_C
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [PC_W-1:0]   out_pc,
   output logic [1:0]        occ
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   logic              w_mv, w_sv;
   logic [DATA_W-1:0] w_md, w_sd;
   logic [PC_W-1:0]   w_mp, w_sp;

   logic              w_flush, w_acc, w_pop;
   logic              w_main_load, w_main_drop, w_skid_load, w_skid_drop;
   logic [PC_W-1:0]   w_inject_pc;
   logic [DATA_W-1:0] w_main_data;
   logic [PC_W-1:0]   w_main_pc;

   assign w_flush     = req | clr;
   assign w_inject_pc = req ? EXC_PC : CLR_PC;
   assign w_acc       = in_valid & ~w_sv;
   assign w_pop       = w_mv & out_ready;

   // main refills from skid when it holds a beat, otherwise from the input
   assign w_main_load = ~w_flush & ((w_acc & (~w_mv | w_pop)) | (w_sv & w_pop));
   assign w_main_drop = ~w_flush & w_pop & ~w_acc & ~w_sv;
   assign w_skid_load = ~w_flush & w_acc & w_mv & ~w_pop;
   assign w_skid_drop = ~w_flush & w_sv & w_pop;
   assign w_main_data = w_sv ? w_sd : in_data;
   assign w_main_pc   = w_sv ? w_sp : in_pc;

   pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(RESET_PC)) u_main (
      .clk       (clk),
      .reset     (reset),
      .flush     (w_flush),
      .inject_pc (w_inject_pc),
      .load      (w_main_load),
      .drop      (w_main_drop),
      .load_data (w_main_data),
      .load_pc   (w_main_pc),
      .valid     (w_mv),
      .data      (w_md),
      .pc        (w_mp)
   );

   pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC('0)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (w_flush),
      .inject_pc ('0),
      .load      (w_skid_load),
      .drop      (w_skid_drop),
      .load_data (in_data),
      .load_pc   (in_pc),
      .valid     (w_sv),
      .data      (w_sd),
      .pc        (w_sp)
   );

   assign in_ready  = ~w_sv;
   assign out_valid = w_mv;
   assign out_data  = w_md;
   assign out_pc    = w_mp;
   assign occ       = {1'b0, w_mv} + {1'b0, w_sv};

`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (w_mv & ~out_ready) stall_cnt <= stall_cnt + 32'd1;
         if (w_flush)           flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_pipe_stage_skid : directed vector table plus corner sequences
// Rev 1.0
// ---------------------------------------------------------------
module tb_pipe_stage_skid;

   logic         clk = 1'b0;
   logic         reset, req, clr, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_data, out_data;
   logic [31:0]  in_pc, out_pc;
   logic [1:0]   occ;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]  stall_cnt;
   logic [15:0]  flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_skid dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_pc    (out_pc),
      .occ       (occ)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   typedef struct {
      logic         req, clr, iv;
      logic [127:0] d;
      logic [31:0]  pc;
      logic         ordy;
      logic         ev;
      logic [127:0] ed;
      logic [31:0]  epc;
      logic [1:0]   eocc;
      logic         eir;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic c, input logic iv, input logic [127:0] d,
                      input logic [31:0] pc, input logic ordy, input logic ev,
                      input logic [127:0] ed, input logic [31:0] epc,
                      input logic [1:0] eocc, input logic eir);
      vec_t v;
      v.req = r; v.clr = c; v.iv = iv; v.d = d; v.pc = pc; v.ordy = ordy;
      v.ev = ev; v.ed = ed; v.epc = epc; v.eocc = eocc; v.eir = eir;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_pc = '0;
   endtask

   initial begin
      reset = 1'b1; out_ready = 1'b0;
      idle();
      in_data = 'x;

      // req clr iv  data        pc   ordy | valid data  pc  occ ir
      add(1'b0,1'b0,1'b1,128'hA1,32'h100,1'b0, 1'b1,128'hA1,32'h100 ,2'd1,1'b1);
      add(1'b0,1'b0,1'b1,128'hB2,32'h104,1'b0, 1'b1,128'hA1,32'h100 ,2'd2,1'b0);
      add(1'b0,1'b0,1'b1,128'hC3,32'h108,1'b0, 1'b1,128'hA1,32'h100 ,2'd2,1'b0);
      add(1'b0,1'b0,1'b0,128'h0 ,32'h0  ,1'b1, 1'b1,128'hB2,32'h104 ,2'd1,1'b1);
      add(1'b0,1'b0,1'b0,128'h0 ,32'h0  ,1'b1, 1'b0,128'hB2,32'h104 ,2'd0,1'b1);
      add(1'b0,1'b0,1'b1,128'hD4,32'h10c,1'b1, 1'b1,128'hD4,32'h10c ,2'd1,1'b1);
      add(1'b0,1'b0,1'b1,128'hE5,32'h110,1'b0, 1'b1,128'hD4,32'h10c ,2'd2,1'b0);
      add(1'b1,1'b0,1'b1,128'hF6,32'h114,1'b0, 1'b0,128'h0 ,32'h4184,2'd0,1'b1);
      add(1'b0,1'b0,1'b0,128'h0 ,32'h0  ,1'b1, 1'b0,128'h0 ,32'h4184,2'd0,1'b1);
      add(1'b0,1'b0,1'b1,128'h77,32'h200,1'b0, 1'b1,128'h77,32'h200 ,2'd1,1'b1);
      add(1'b1,1'b1,1'b0,128'h0 ,32'h0  ,1'b0, 1'b0,128'h0 ,32'h4184,2'd0,1'b1);
      add(1'b0,1'b0,1'b1,128'h88,32'h300,1'b1, 1'b1,128'h88,32'h300 ,2'd1,1'b1);
      add(1'b0,1'b1,1'b0,128'h0 ,32'h0  ,1'b1, 1'b0,128'h0 ,32'h0   ,2'd0,1'b1);
      add(1'b0,1'b0,1'b1,128'h99,32'h304,1'b1, 1'b1,128'h99,32'h304 ,2'd1,1'b1);
      add(1'b0,1'b0,1'b1,128'hAA,32'h308,1'b1, 1'b1,128'hAA,32'h308 ,2'd1,1'b1);
      add(1'b0,1'b0,1'b0,128'h0 ,32'h0  ,1'b0, 1'b1,128'hAA,32'h308 ,2'd1,1'b1);
      add(1'b0,1'b0,1'b0,128'h0 ,32'h0  ,1'b1, 1'b0,128'hAA,32'h308 ,2'd0,1'b1);

      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_data",  out_data,  '0);
      check("rst_pc",    out_pc,    32'h3004);
      check("rst_occ",   occ,       2'd0);
      check("rst_ready", in_ready,  1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req; clr = vecs[i].clr; in_valid = vecs[i].iv;
         in_data = vecs[i].d; in_pc = vecs[i].pc; out_ready = vecs[i].ordy;
         tick();
         check($sformatf("v%0d_valid", i), out_valid, vecs[i].ev);
         check($sformatf("v%0d_data", i),  out_data,  vecs[i].ed);
         check($sformatf("v%0d_pc", i),    out_pc,    vecs[i].epc);
         check($sformatf("v%0d_occ", i),   occ,       vecs[i].eocc);
         check($sformatf("v%0d_ready", i), in_ready,  vecs[i].eir);
      end
      idle();

      // out_ready must not reach in_ready combinationally
      out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h11; in_pc = 32'h400;
      tick();
      in_data = 128'h12; in_pc = 32'h404;
      tick();
      in_valid = 1'b0; in_data = 'x;
      check("comb_ready_before", in_ready, 1'b0);
      out_ready = 1'b1;
      #1;
      check("comb_ready_same_cycle", in_ready, 1'b0);
      check("comb_occ", occ, 2'd2);
      tick();
      check("comb_ready_after_pop", in_ready, 1'b1);
      check("comb_promote_data", out_data, 128'h12);
      tick();
      check("comb_drained", out_valid, 1'b0);

      // streaming, one beat per cycle
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 128'(i); in_pc = 32'h3000 + 32'(4 * i);
         tick();
         check($sformatf("s%0d_valid", i), out_valid, 1'b1);
         check($sformatf("s%0d_data", i),  out_data,  128'(i));
         check($sformatf("s%0d_pc", i),    out_pc,    32'h3000 + 32'(4 * i));
         check($sformatf("s%0d_occ_le1", i), (occ <= 2'd1), 1'b1);
      end
      in_valid = 1'b0; in_data = 'x;
      tick();
      check("stream_end_valid", out_valid, 1'b0);

      // asynchronous reset mid-cycle with a beat on offer
      out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h33; in_pc = 32'h500;
      tick();
      check("ar_loaded", out_valid, 1'b1);
      #3 reset = 1'b1;
      #1;
      check("ar_valid", out_valid, 1'b0);
      check("ar_pc",    out_pc,    32'h3004);
      check("ar_occ",   occ,       2'd0);
      check("ar_ready", in_ready,  1'b1);
      tick();
      check("ar_held_valid", out_valid, 1'b0);
      reset = 1'b0; in_data = 128'h55; in_pc = 32'h600;
      #1;
      check("ar_pre_accept", out_valid, 1'b0);
      tick();
      check("ar_first_valid", out_valid, 1'b1);
      check("ar_first_data",  out_data,  128'h55);
      check("ar_first_pc",    out_pc,    32'h600);
      idle();
      out_ready = 1'b1;
      tick();

`ifdef PIPE_STAGE_PERF_EN
      reset = 1'b1; #2 reset = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h66; in_pc = 32'h700;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      out_ready = 1'b1; req = 1'b1;
      tick();
      req = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      check("perf_stall", stall_cnt, 32'd5);
      check("perf_flush", flush_cnt, 16'd2);
      #2 reset = 1'b1;
      #1;
      check("perf_stall_rst", stall_cnt, 32'd0);
      check("perf_flush_rst", flush_cnt, 16'd0);
      reset = 1'b0;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
